// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and width helper for the sequential ALU.
package alu_pkg;

    localparam logic [1:0] OP_SUB   = 2'd0;
    localparam logic [1:0] OP_NAND  = 2'd1;
    localparam logic [1:0] OP_LONES = 2'd2;
    localparam logic [1:0] OP_OHDEC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Scan results must hold a count of up to 2W and still cover a WIDTH-bit slice.
    function automatic int res_width(input int width);
        int cw;
        cw = $clog2(2 * width + 1);
        return (cw > width) ? cw : width;
    endfunction

endpackage

// File: rtl/alu_seq_scanner.sv
// Bit-serial scanner over {B,A}: leading-ones count (MSB first) or one-hot decode (LSB first).
module serial_bit_scanner
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          lsb_first,
    input  logic                          en,
    input  logic [2*WIDTH-1:0]            vec,
    output logic                          done,
    output logic [res_width(WIDTH)-1:0]   res,
    output logic                          err
);

    localparam int N2 = 2 * WIDTH;
    localparam int IW = $clog2(N2);
    localparam int RW = res_width(WIDTH);

    logic [N2-1:0] sr;
    logic          lsb;
    logic [IW-1:0] idx;
    logic [RW-1:0] cnt;
    logic [IW-1:0] first;
    logic          found;
    logic          cur_bit;
    logic          last;

    assign cur_bit = lsb ? sr[0] : sr[N2-1];
    assign last    = (idx == IW'(N2 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            lsb   <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            first <= '0;
            found <= 1'b0;
        end else if (start) begin
            sr    <= vec;
            lsb   <= lsb_first;
            idx   <= '0;
            cnt   <= '0;
            first <= '0;
            found <= 1'b0;
        end else if (en) begin
            sr  <= lsb ? (sr >> 1) : (sr << 1);
            idx <= idx + IW'(1);
            if (cur_bit) begin
                cnt <= cnt + RW'(1);
            end
            if (cur_bit && !found) begin
                found <= 1'b1;
                first <= idx;
            end
        end
    end

    // Termination is decided on the bit examined this cycle, so done is combinational.
    always_comb begin
        done = 1'b0;
        res  = '0;
        err  = 1'b0;
        if (en) begin
            if (lsb) begin
                if (cur_bit && found) begin
                    done = 1'b1;
                    err  = 1'b1;
                    res  = RW'(first);
                end else if (last) begin
                    done = 1'b1;
                    if (found) begin
                        res = RW'(first);
                    end else if (cur_bit) begin
                        res = RW'(idx);
                    end
                    err = !(found || cur_bit);
                end
            end else begin
                if (!cur_bit || last) begin
                    done = 1'b1;
                    res  = cnt + RW'(cur_bit);
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle SUB/NAND, bit-serial LONES/OHDEC, sticky flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_overflow,
    output logic             o_err,
    input  logic             i_clr_status,
    output logic             o_sticky_ovf,
    output logic             o_sticky_err,
    output logic [1:0]       o_dbg_state
);

    localparam int RW = res_width(WIDTH);

    // Handshake: a request transfers on an edge where i_valid && o_ready; a result
    // transfers on an edge where o_valid && i_ready. Neither side may retract early.

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic            scan_start;
    logic            scan_en;
    logic            scan_done;
    logic [RW-1:0]   scan_res;
    logic            scan_err;
    logic            is_scan_op;
    logic [WIDTH-1:0] diff;
    logic            load;
    logic [WIDTH-1:0] y_d;
    logic            ovf_d;
    logic            err_d;

    assign is_scan_op = (i_op == OP_LONES) || (i_op == OP_OHDEC);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (i_valid) state_nx = is_scan_op ? ST_SCAN : ST_DONE;
            ST_SCAN: if (scan_done) state_nx = ST_DONE;
            ST_DONE: if (i_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (state == ST_IDLE);
        o_valid     = (state == ST_DONE);
        accept      = i_valid && (state == ST_IDLE);
        scan_start  = accept && is_scan_op;
        scan_en     = (state == ST_SCAN);
        o_dbg_state = state;
    end

    serial_bit_scanner #(
        .WIDTH(WIDTH)
    ) u_scanner (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (scan_start),
        .lsb_first (i_op == OP_OHDEC),
        .en        (scan_en),
        .vec       ({i_b, i_a}),
        .done      (scan_done),
        .res       (scan_res),
        .err       (scan_err)
    );

    always_comb begin
        diff  = i_a - i_b;
        load  = 1'b0;
        y_d   = '0;
        ovf_d = 1'b0;
        err_d = 1'b0;
        if (accept && i_op == OP_SUB) begin
            load  = 1'b1;
            y_d   = diff;
            ovf_d = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (i_a[WIDTH-1] != diff[WIDTH-1]);
        end else if (accept && i_op == OP_NAND) begin
            load = 1'b1;
            y_d  = ~(i_a & i_b);
        end else if (scan_en && scan_done) begin
            load  = 1'b1;
            y_d   = scan_res[WIDTH-1:0];
            ovf_d = (scan_res >> WIDTH) != '0;
            err_d = scan_err;
        end
    end

    // A flag being set on DONE entry beats a coincident clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_y          <= '0;
            o_overflow   <= 1'b0;
            o_err        <= 1'b0;
            o_sticky_ovf <= 1'b0;
            o_sticky_err <= 1'b0;
        end else begin
            if (load) begin
                o_y        <= y_d;
                o_overflow <= ovf_d;
                o_err      <= err_d;
            end
            o_sticky_ovf <= (o_sticky_ovf && !i_clr_status) || (load && ovf_d);
            o_sticky_err <= (o_sticky_err && !i_clr_status) || (load && err_d);
        end
    end

endmodule
